// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing constants, derived totals, and the
// Buscaminas 8x8 board geometry shared with the cell-position decoder.
package vga_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Board is 8x8 cells of 48 px, centred horizontally in the visible area.
  localparam int unsigned GRID_COLS = 8;
  localparam int unsigned GRID_ROWS = 8;
  localparam int unsigned CELL_PX   = 48;
  localparam int unsigned BOARD_X0  = 128;
  localparam int unsigned BOARD_Y0  = 48;
  localparam int unsigned BOARD_X1  = BOARD_X0 + GRID_COLS * CELL_PX;
  localparam int unsigned BOARD_Y1  = BOARD_Y0 + GRID_ROWS * CELL_PX;

  function automatic logic in_window(input logic [CNT_W-1:0] v,
                                     input logic [CNT_W-1:0] first,
                                     input logic [CNT_W-1:0] last);
    return (v >= first) && (v <= last);
  endfunction

endpackage

// File: rtl/pixel_strobe.sv
// pixel_strobe: divide-by-2 pixel enable from a toggle flop; only built when
// VGA_PIXEL_DIV_EN is defined (2x clock build).
`ifdef VGA_PIXEL_DIV_EN
module pixel_strobe (
  input  logic clk,
  input  logic rst,
  output logic pix_en
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pix_en <= 1'b0;
    else     pix_en <= ~pix_en;
  end

endmodule
`endif

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters, negative syncs, video-active and line/frame strobes.
// Define VGA_PIXEL_DIV_EN to run from a 2x clock with an internal divide-by-2 pixel enable.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] hs,
  output logic [CNT_W-1:0] vs,
  output logic             hsync_n,
  output logic             vsync_n,
  output logic             video_on,
  output logic             pix_en,
  output logic             line_start,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_FIRST = H_ACTIVE + H_FP;
  localparam int unsigned HS_LAST  = HS_FIRST + H_SYNC - 1;
  localparam int unsigned VS_FIRST = V_ACTIVE + V_FP;
  localparam int unsigned VS_LAST  = VS_FIRST + V_SYNC - 1;
  localparam int unsigned CNT_MAX  = 1 << CNT_W;

  if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL or V_TOTAL exceeds the 10-bit counter range");
  end

  logic             strobe;
  logic [CNT_W-1:0] hs_nxt;
  logic [CNT_W-1:0] vs_nxt;
  logic             h_wrap;
  logic             v_wrap;

`ifdef VGA_PIXEL_DIV_EN
  pixel_strobe u_pixel_strobe (
    .clk    (clk),
    .rst    (rst),
    .pix_en (strobe)
  );
`else
  assign strobe = 1'b1;
`endif

  assign pix_en = strobe;

  // Next raster position; holds between strobes.
  always_comb begin
    hs_nxt = hs;
    vs_nxt = vs;
    h_wrap = 1'b0;
    v_wrap = 1'b0;
    if (strobe) begin
      if (hs == CNT_W'(H_TOTAL - 1)) begin
        hs_nxt = '0;
        h_wrap = 1'b1;
        if (vs == CNT_W'(V_TOTAL - 1)) begin
          vs_nxt = '0;
          v_wrap = 1'b1;
        end else begin
          vs_nxt = vs + CNT_W'(1);
        end
      end else begin
        hs_nxt = hs + CNT_W'(1);
      end
    end
  end

  // Decodes come from the next-state counters so they line up with hs/vs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs          <= '0;
      vs          <= '0;
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hs          <= hs_nxt;
      vs          <= vs_nxt;
      line_start  <= h_wrap;
      frame_start <= v_wrap;
      if (strobe) begin
        hsync_n  <= ~in_window(hs_nxt, CNT_W'(HS_FIRST), CNT_W'(HS_LAST));
        vsync_n  <= ~in_window(vs_nxt, CNT_W'(VS_FIRST), CNT_W'(VS_LAST));
        video_on <= (hs_nxt < CNT_W'(H_ACTIVE)) && (vs_nxt < CNT_W'(V_ACTIVE));
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: self-checking bench; a full-size instance plus a tiny-raster
// instance so frame wraps are reachable in a short run.
module tb_vga_timing_gen;

`ifdef VGA_PIXEL_DIV_EN
  localparam int K = 2;
`else
  localparam int K = 1;
`endif
  localparam logic [24:0] RST_OBS = {10'd0, 10'd0, 5'b11000};
  localparam int SFRAME = 15 * 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  logic [9:0] b_hs, b_vs, s_hs, s_vs;
  logic b_hsn, b_vsn, b_vid, b_pe, b_ls, b_fs;
  logic s_hsn, s_vsn, s_vid, s_pe, s_ls, s_fs;
  logic [24:0] b_obs, s_obs;
  assign b_obs = {b_hs, b_vs, b_hsn, b_vsn, b_vid, b_ls, b_fs};
  assign s_obs = {s_hs, s_vs, s_hsn, s_vsn, s_vid, s_ls, s_fs};

  vga_timing_gen u_big (
    .clk(clk), .rst(rst), .hs(b_hs), .vs(b_vs), .hsync_n(b_hsn), .vsync_n(b_vsn),
    .video_on(b_vid), .pix_en(b_pe), .line_start(b_ls), .frame_start(b_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_sml (
    .clk(clk), .rst(rst), .hs(s_hs), .vs(s_vs), .hsync_n(s_hsn), .vsync_n(s_vsn),
    .video_on(s_vid), .pix_en(s_pe), .line_start(s_ls), .frame_start(s_fs)
  );

  int errors = 0;
  int checks = 0;

  // Reference: strobes since reset, plus whether the last clk edge was a strobe.
  longint n;
  bit     adv;
  bit     m_phase;
  logic   exp_pe;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n <= 0; adv <= 1'b0; m_phase <= 1'b0;
    end else begin
`ifdef VGA_PIXEL_DIV_EN
      m_phase <= !m_phase;
      adv     <= m_phase;
      if (m_phase) n <= n + 1;
`else
      adv <= 1'b1;
      n   <= n + 1;
`endif
    end
  end
`ifdef VGA_PIXEL_DIV_EN
  assign exp_pe = m_phase;
`else
  assign exp_pe = 1'b1;
`endif

  function automatic logic [24:0] exp_obs(input longint cnt, input bit a,
      input longint ha, input longint hf, input longint hw, input longint hb,
      input longint va, input longint vf, input longint vw, input longint vb);
    longint ht, vt, h, v;
    logic hsn, vsn, vid, ls, fs;
    ht  = ha + hf + hw + hb;
    vt  = va + vf + vw + vb;
    h   = cnt % ht;
    v   = (cnt / ht) % vt;
    hsn = !(h >= ha + hf && h < ha + hf + hw);
    vsn = !(v >= va + vf && v < va + vf + vw);
    vid = (cnt > 0) && (h < ha) && (v < va);
    ls  = a && (h == 0);
    fs  = ls && (v == 0);
    return {10'(h), 10'(v), hsn, vsn, vid, ls, fs};
  endfunction

  function automatic logic [24:0] exp_big();
    return exp_obs(n, adv, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  function automatic logic [24:0] exp_sml();
    return exp_obs(n, adv, 8, 2, 3, 2, 6, 2, 2, 3);
  endfunction

  task automatic test_reset();
    bit got;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (b_obs !== RST_OBS) begin errors++; $display("FAIL reset_big got=%h exp=%h", b_obs, RST_OBS); end
    checks++; if (s_obs !== RST_OBS) begin errors++; $display("FAIL reset_sml got=%h exp=%h", s_obs, RST_OBS); end
    checks++; if (b_pe !== exp_pe) begin errors++; $display("FAIL reset_pix_en got=%b exp=%b", b_pe, exp_pe); end
    rst = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (adv) got = 1'b1;
      else begin
        checks++; if (b_hs !== 10'd0 || b_vid !== 1'b0) begin errors++; $display("FAIL pre_strobe_hold got hs=%0d vid=%b exp hs=0 vid=0", b_hs, b_vid); end
      end
    end
    checks++;
    if (!got) begin errors++; $display("FAIL first_strobe_timeout got none exp strobe within 4 clk"); end
    else if (b_hs !== 10'd1 || b_vid !== 1'b1 || s_hs !== 10'd1 || s_vid !== 1'b1) begin
      errors++; $display("FAIL first_advance got hs=%0d/%0d vid=%b/%b exp hs=1 vid=1", b_hs, s_hs, b_vid, s_vid);
    end
  endtask

  task automatic test_pix_en();
    int since = 0;
    logic [9:0] phs;
    phs = b_hs;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++; if (b_pe !== exp_pe || s_pe !== exp_pe) begin errors++; $display("FAIL pix_en got=%b/%b exp=%b", b_pe, s_pe, exp_pe); end
      if (b_hs !== phs) begin
        if (since != 0) begin
          checks++; if (since !== K) begin errors++; $display("FAIL hs_step_period got=%0d exp=%0d clk", since, K); end
        end
        since = 1;
      end else if (since != 0) since++;
      phs = b_hs;
    end
  endtask

  task automatic test_hsync();
    bit prev = 1'b1;
    int cnt = 0, pulses = 0;
    logic [24:0] e;
    for (int i = 0; i < 1700 * K; i++) begin
      @(negedge clk);
      e = exp_big();
      checks++; if (b_obs !== e) begin errors++; $display("FAIL hsync_trace n=%0d got=%h exp=%h", n, b_obs, e); end
      if (adv) begin
        if (prev && !b_hsn) begin
          checks++; if (b_hs !== 10'd656) begin errors++; $display("FAIL hsync_fall got hs=%0d exp 656", b_hs); end
          cnt = 1;
        end else if (!prev && !b_hsn) cnt++;
        else if (!prev && b_hsn) begin
          checks++;
          if (b_hs !== 10'd752 || cnt !== 96) begin errors++; $display("FAIL hsync_rise got hs=%0d width=%0d exp hs=752 width=96", b_hs, cnt); end
          pulses++;
        end
        prev = b_hsn;
      end
    end
    checks++; if (pulses < 2) begin errors++; $display("FAIL hsync_pulses got=%0d exp>=2", pulses); end
  endtask

  task automatic test_line_wrap();
    int last = 0, seen = 0;
    logic [9:0] pvs;
    pvs = b_vs;
    for (int c = 0; c < 2000 * K && seen < 2; c++) begin
      @(negedge clk);
      if (b_ls) begin
        checks++;
        if (b_hs !== 10'd0 || b_vs !== pvs + 10'd1) begin
          errors++; $display("FAIL line_wrap got hs=%0d vs=%0d exp hs=0 vs=%0d", b_hs, b_vs, pvs + 10'd1);
        end
        if (seen > 0) begin
          checks++; if (c - last !== 800 * K) begin errors++; $display("FAIL line_length got=%0d exp=%0d clk", c - last, 800 * K); end
        end
        last = c;
        seen++;
        @(negedge clk);
        c++;
        checks++; if (b_ls !== 1'b0) begin errors++; $display("FAIL line_start_width got=%b exp=0", b_ls); end
      end
      pvs = b_vs;
    end
    checks++; if (seen < 2) begin errors++; $display("FAIL line_start_timeout got=%0d exp 2 pulses", seen); end
  endtask

  task automatic test_frame();
    longint f0;
    int fs_cnt = 0;
    logic [9:0] phs, pvs;
    logic [24:0] e;
    f0 = n / SFRAME;
    phs = s_hs; pvs = s_vs;
    for (int i = 0; i < 600 * K; i++) begin
      @(negedge clk);
      e = exp_sml();
      checks++; if (s_obs !== e) begin errors++; $display("FAIL frame_trace n=%0d got=%h exp=%h", n, s_obs, e); end
      if (!s_vsn) begin
        checks++; if (s_vs !== 10'd8 && s_vs !== 10'd9) begin errors++; $display("FAIL vsync_window got vs=%0d exp 8..9", s_vs); end
      end
      if (s_fs) begin
        fs_cnt++;
        checks++;
        if (!s_ls || phs !== 10'd14 || pvs !== 10'd12 || s_hs !== 10'd0 || s_vs !== 10'd0) begin
          errors++; $display("FAIL frame_wrap got ls=%b from (%0d,%0d) to (%0d,%0d) exp ls=1 (14,12)->(0,0)", s_ls, phs, pvs, s_hs, s_vs);
        end
      end
      phs = s_hs; pvs = s_vs;
    end
    checks++; if (longint'(fs_cnt) !== n / SFRAME - f0) begin errors++; $display("FAIL frame_count got=%0d exp=%0d", fs_cnt, n / SFRAME - f0); end
  endtask

  task automatic test_video_boundaries();
    logic [5:0] hit = '0;
    for (int i = 0; i < 900 * K; i++) begin
      @(negedge clk);
      if (adv) begin
        if (s_hs == 10'd7 && s_vs == 10'd5) begin hit[0] = 1'b1; checks++; if (s_vid !== 1'b1) begin errors++; $display("FAIL vid_last_active got=%b exp=1", s_vid); end end
        if (s_hs == 10'd8 && s_vs == 10'd5) begin hit[1] = 1'b1; checks++; if (s_vid !== 1'b0) begin errors++; $display("FAIL vid_h_edge got=%b exp=0", s_vid); end end
        if (s_hs == 10'd0 && s_vs == 10'd6) begin hit[2] = 1'b1; checks++; if (s_vid !== 1'b0) begin errors++; $display("FAIL vid_v_edge got=%b exp=0", s_vid); end end
        if (s_hs == 10'd0 && s_vs == 10'd0) begin hit[3] = 1'b1; checks++; if (s_vid !== 1'b1) begin errors++; $display("FAIL vid_frame_origin got=%b exp=1", s_vid); end end
        if (b_hs == 10'd639) begin hit[4] = 1'b1; checks++; if (b_vid !== 1'b1) begin errors++; $display("FAIL vid_639 got=%b exp=1", b_vid); end end
        if (b_hs == 10'd640) begin hit[5] = 1'b1; checks++; if (b_vid !== 1'b0) begin errors++; $display("FAIL vid_640 got=%b exp=0", b_vid); end end
      end
    end
    checks++; if (hit !== 6'b111111) begin errors++; $display("FAIL vid_points_reached got=%b exp=111111", hit); end
  endtask

  task automatic test_mid_reset();
    bit ok;
    int target;
    logic [24:0] e;
    for (int r = 0; r < 2; r++) begin
      ok = 1'b0;
      target = int'($urandom_range(20, 700));
      for (int c = 0; c < 1700 * K && !ok; c++) begin
        @(negedge clk);
        if (r == 0 ? (b_hs == 10'd300) : (c >= target)) ok = 1'b1;
      end
      checks++; if (!ok) begin errors++; $display("FAIL mid_reset_setup_timeout round=%0d", r); end
      rst = 1'b1;
      #1;
      checks++; if (b_obs !== RST_OBS || s_obs !== RST_OBS) begin errors++; $display("FAIL async_reset got=%h/%h exp=%h", b_obs, s_obs, RST_OBS); end
      @(negedge clk);
      checks++; if (b_obs !== RST_OBS || b_pe !== exp_pe) begin errors++; $display("FAIL reset_hold got=%h pe=%b exp=%h pe=%b", b_obs, b_pe, RST_OBS, exp_pe); end
      rst = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 4 && !ok; i++) begin
        @(negedge clk);
        if (adv) ok = 1'b1;
      end
      checks++;
      if (!ok || b_hs !== 10'd1 || b_vid !== 1'b1) begin
        errors++; $display("FAIL post_reset_advance got strobe=%b hs=%0d vid=%b exp hs=1 vid=1", ok, b_hs, b_vid);
      end
      for (int i = 0; i < int'($urandom_range(100, 400)) * K; i++) begin
        @(negedge clk);
        e = exp_big();
        checks++; if (b_obs !== e) begin errors++; $display("FAIL post_reset_big n=%0d got=%h exp=%h", n, b_obs, e); end
        e = exp_sml();
        checks++; if (s_obs !== e) begin errors++; $display("FAIL post_reset_sml n=%0d got=%h exp=%h", n, s_obs, e); end
      end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pix_en();
    test_hsync();
    test_line_wrap();
    test_frame();
    test_video_boundaries();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the 640x480@60 Hz VGA raster timing for the Buscaminas display path. It sits directly upstream of the cell-position decoder and drives the 10-bit horizontal/vertical pixel counters that the decoder compares against the 8x8 board geometry. It also drives the active-low sync outputs to the VGA DAC/connector, plus a video-active flag and line/frame strobes for the renderer and game logic.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- clk  input  1  system clock; 25 MHz pixel clock, or 50 MHz when VGA_PIXEL_DIV_EN is defined
- rst  input  1  asynchronous, active-high reset
- hs  output  10  horizontal pixel counter, 0..H_TOTAL-1
- vs  output  10  vertical line counter, 0..V_TOTAL-1
- hsync_n  output  1  horizontal sync, active low
- vsync_n  output  1  vertical sync, active low
- video_on  output  1  high while hs < H_ACTIVE and vs < V_ACTIVE
- pix_en  output  1  pixel strobe; the counters advance only on clk edges where pix_en = 1
- line_start  output  1  one-clk pulse when hs wraps to 0
- frame_start  output  1  one-clk pulse when hs and vs both wrap to 0

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default). V_TOTAL is defined the same way (525 by default).
- Counter behaviour on each pix_en:
  - hs increments.
  - At H_TOTAL-1, hs wraps to 0 and vs increments.
  - At V_TOTAL-1 with the hs wrap, vs wraps to 0.
- The counters hold when pix_en = 0.
- Sync windows:
  - hsync_n = 0 for hs in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751 by default.
  - vsync_n = 0 for vs in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491 by default.
- hsync_n, vsync_n and video_on are registered from the next-state counter values, so they are always consistent with the hs/vs values in the same cycle.
- line_start and frame_start are registered and high for exactly one clk, on the cycle where hs/vs first show the wrapped value.
- Arithmetic:
  - Unsigned 10-bit.
  - Elaboration-time check: H_TOTAL <= 1024 and V_TOTAL <= 1024, otherwise $error.
- Counters never exceed TOTAL-1. No out-of-range state is reachable.

## Timing
- Reset values, applied immediately on rst assertion (asynchronous):
  - hs = 0, vs = 0
  - hsync_n = 1, vsync_n = 1
  - video_on = 0
  - line_start = 0, frame_start = 0
  - internal divider phase = 0
- Reset during operation: all outputs return to the reset values asynchronously, regardless of position in the line or frame.
- First advance after reset: on the first pix_en edge after rst deassertion, hs becomes 1 and video_on becomes 1.
- Line timing: one line lasts H_TOTAL pix_en strobes. One frame lasts H_TOTAL*V_TOTAL strobes (420000 by default).
- Latency: output changes appear on the same clk edge as the counter update, with no extra pipeline stage.
- Simultaneous wrap at (H_TOTAL-1, V_TOTAL-1): line_start and frame_start assert in the same cycle.
- Sync polarities are fixed negative, matching 640x480@60.

## Configuration
- VGA_PIXEL_DIV_EN defined:
  - clk is 50 MHz.
  - An internal toggle flop generates pix_en, which is high every second clk. The first pix_en = 1 occurs on the second rising clk edge after rst deasserts.
  - All outputs change only on pix_en cycles. line_start and frame_start are still one clk wide.
- VGA_PIXEL_DIV_EN undefined:
  - clk is the 25 MHz pixel clock.
  - pix_en is tied to 1, and the counters advance on every clk.

## Structure
- Shared package vga_pkg holds:
  - the default timing constants and the derived H_TOTAL / V_TOTAL
  - the cell geometry constants used by the position decoder (column and row boundaries, grid size 8x8)
- One sub-module, pixel_strobe:
  - the divide-by-2 clock-enable generator
  - instantiated only under VGA_PIXEL_DIV_EN

## Test plan
- Reset check: assert rst mid-frame at hs = 300, vs = 200 -> hs = 0, vs = 0, hsync_n = 1, vsync_n = 1, video_on = 0 with no clk edge; after release, the first pix_en gives hs = 1 and video_on = 1.
- Horizontal sync: hsync_n falls when hs = 656 and rises when hs = 752; the low pulse lasts exactly 96 pix_en strobes, every line.
- Line length: hs wraps from 799 to 0 with line_start = 1 for one clk, and vs increments by 1 in that same cycle.
- Vertical sync and frame: vsync_n = 0 only for vs = 490 and 491; frame_start pulses once per 420000 strobes, coincident with line_start, at the wrap from (799, 524) to (0, 0).
- Video active boundaries: video_on = 1 at (639, 479); 0 at (640, 479); 0 at (0, 480); back to 1 at (0, 0).
- VGA_PIXEL_DIV_EN build: pix_en alternates 0/1 each clk, a full line takes 1600 clk, and hs holds for one clk between increments.
